// File: rtl/ysyx_22051013_axi_ifu_rd_slave_pkg.sv
// rtl/ysyx_22051013_axi_ifu_rd_slave_pkg.sv - shared AXI response codes for the IFU read slave
package ysyx_22051013_axi_ifu_rd_slave_pkg;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22051013_axi_ifu_rd_slave.sv
// rtl/ysyx_22051013_axi_ifu_rd_slave.sv - single-outstanding AXI read slave in front of the instruction SRAM
module ysyx_22051013_axi_ifu_rd_slave
    import ysyx_22051013_axi_ifu_rd_slave_pkg::*;
#(
    parameter int                  ADDR_W   = 64,
    parameter int                  DATA_W   = 64,
    parameter int                  LATENCY  = 2,
    parameter logic [ADDR_W-1:0]   MEM_BASE = 64'h8000_0000,
    parameter logic [ADDR_W-1:0]   MEM_SIZE = 64'h0800_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic                ar_valid,
    output logic                ar_ready,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_valid,
    input  logic                r_ready,
    output logic                mem_en,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    // Window bounds widened by one bit so BASE+SIZE cannot wrap at the top of the address space.
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, MEM_BASE};
    localparam logic [ADDR_W:0] WIN_HI = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_ar_ready;

    logic               w_hs_ar;
    logic               w_hs_r;
    logic               w_last;
    logic [ADDR_W:0]    w_addr_ext;
    resp_t              w_resp;

    assign w_hs_ar    = ar_valid & r_ar_ready;
    assign w_hs_r     = r_valid & r_ready;
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_addr_ext = {1'b0, ar_addr};
    assign ar_ready   = r_ar_ready;
    assign mem_addr   = r_addr & ~ADDR_W'(7);

    // Address decode: out-of-window beats misalignment.
    always_comb begin
        w_resp = RESP_OKAY;
        if ((w_addr_ext < WIN_LO) || (w_addr_ext >= WIN_HI)) begin
            w_resp = RESP_DECERR;
        end else if (ar_addr[1:0] != 2'b00) begin
            w_resp = RESP_SLVERR;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: errors skip ACCESS, OK reads spend LATENCY cycles there.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs_ar) begin
                    w_state_nxt = (w_resp == RESP_OKAY) ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                if (w_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_hs_r) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // SRAM strobe only in the first ACCESS cycle.
    always_comb begin
        mem_en = (r_state == S_ACCESS) && (r_cnt == '0);
    end

    // Registered outputs: ar_ready tracks the upcoming state so it stays low through reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ar_ready <= 1'b0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_data     <= '0;
            r_resp     <= RESP_OKAY;
            r_valid    <= 1'b0;
        end else begin
            r_ar_ready <= (w_state_nxt == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_hs_ar) begin
                        r_addr <= ar_addr;
                        r_cnt  <= '0;
                        if (w_resp != RESP_OKAY) begin
                            r_data  <= '0;
                            r_resp  <= w_resp;
                            r_valid <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_last) begin
                        r_data  <= mem_rdata;
                        r_resp  <= RESP_OKAY;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_hs_r) begin
                        r_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
